// File: rtl/snn_fifo_pkg.sv
// snn_fifo_pkg: shared widths, the tagged FIFO word and saturating-count helper for the spike FIFO arbiter
package snn_fifo_pkg;
  function automatic int src_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_DATA_W = 8;
  typedef struct packed {
    logic [src_w(DEF_NUM_SRC)-1:0] src_id;
    logic [DEF_DATA_W-1:0] data;
  } fifo_word_t;
  // Increments v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    return (v == (64'd1 << w) - 64'd1) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/spike_fifo_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter
  import snn_fifo_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = src_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // Scanning farthest-first lets the nearest requester overwrite the result.
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (enable && req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/spike_fifo_arb.sv
// spike_fifo_arb: round-robin sharing of one fifo_sync write port with a registered, source-tagged push stage
module spike_fifo_arb
  import snn_fifo_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int SRC_W = src_w(NUM_SRC),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr_stats,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic                      fifo_push,
  output logic [SRC_W+DATA_W-1:0]   fifo_push_data,
  input  logic                      fifo_full,
  input  logic [CW-1:0]             fifo_count,
  output logic                      busy,
  output logic [CNT_W-1:0]          accept_cnt,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      ovf_err
);
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d, idx;
  logic fifo_push_q, fifo_push_d, ovf_err_q, ovf_err_d, space, xfer;
  logic [SRC_W+DATA_W-1:0] fifo_push_data_q, fifo_push_data_d;
  logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d, stall_cnt_q, stall_cnt_d;
  // The pending push is not yet in fifo_count, so count it here; pops are ignored.
  assign space = ({1'b0, fifo_count} + (CW + 1)'(fifo_push_q)) < (CW + 1)'(FIFO_DEPTH);
  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req(req_valid), .ptr(rr_ptr_q), .enable(en & space & ~rst), .grant(req_ready), .idx(idx)
  );
  assign xfer = |req_ready;
  always_comb begin
    rr_ptr_d = xfer ? ((int'(idx) == NUM_SRC - 1) ? '0 : idx + 1'b1) : rr_ptr_q;
    fifo_push_d = xfer;
    fifo_push_data_d = xfer ? {idx, req_data[int'(idx)*DATA_W +: DATA_W]} : fifo_push_data_q;
    accept_cnt_d = clr_stats ? '0 : xfer ? CNT_W'(sat_inc(64'(accept_cnt_q), CNT_W)) : accept_cnt_q;
    stall_cnt_d = clr_stats ? '0 : (en & |req_valid & ~space) ? CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W)) : stall_cnt_q;
    ovf_err_d = ~clr_stats & (ovf_err_q | (fifo_push_q & fifo_full));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      fifo_push_q <= 1'b0;
      fifo_push_data_q <= '0;
      accept_cnt_q <= '0;
      stall_cnt_q <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      fifo_push_q <= fifo_push_d;
      fifo_push_data_q <= fifo_push_data_d;
      accept_cnt_q <= accept_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      ovf_err_q <= ovf_err_d;
    end
  end
  assign fifo_push = fifo_push_q;
  assign fifo_push_data = fifo_push_data_q;
  assign accept_cnt = accept_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign ovf_err = ovf_err_q;
  assign busy = fifo_push_q | (|req_valid);
endmodule

// File: tb/tb_spike_fifo_arb.sv
// tb_spike_fifo_arb: scenario tasks with a scoreboard of expected {src_id, data} pushes
`timescale 1ns/1ps
module tb_spike_fifo_arb;
  import snn_fifo_pkg::*;
  logic clk = 0, rst = 0, en = 0, clr_stats = 0, fifo_full = 0;
  logic [3:0] req_valid = 0, req_ready;
  logic [31:0] req_data = 0;
  logic fifo_push, busy, ovf_err;
  logic [9:0] fifo_push_data;
  logic [4:0] fifo_count = 0;
  logic [15:0] accept_cnt, stall_cnt;
  int checks = 0, errors = 0;
  fifo_word_t sb[$];

  spike_fifo_arb dut (
    .clk(clk), .rst(rst), .en(en), .clr_stats(clr_stats), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .fifo_push(fifo_push),
    .fifo_push_data(fifo_push_data), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .busy(busy), .accept_cnt(accept_cnt), .stall_cnt(stall_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; req_valid = 4'hF; req_data = 32'h44332211;
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || fifo_push !== 1'b0 || fifo_push_data !== 10'h0 ||
        accept_cnt !== 16'h0 || stall_cnt !== 16'h0 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b push=%b data=%h acc=%h stall=%h ovf=%b, expected all zero",
               req_ready, fifo_push, fifo_push_data, accept_cnt, stall_cnt, ovf_err);
    end
    tick();
    rst = 0; req_valid = 0;
  endtask

  task automatic test_single();
    do_reset();
    en = 1; fifo_count = 0; req_valid = 4'b0100; req_data = 32'h005A0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    sb.push_back('{src_id: 2'd2, data: 8'h5A});
    tick();
    req_valid = 0;
    @(negedge clk);
    checks++;
    if (fifo_push !== 1'b1 || sb.size() == 0 || fifo_push_data !== sb[0] || accept_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_push: push=%b data=%h acc=%0d expected push=1 data=%h acc=1",
               fifo_push, fifo_push_data, accept_cnt, sb[0]);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    en = 1; fifo_count = 0; req_data = 32'h13121110; req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got %b expected %b", k, req_ready, 4'(1 << (k % 4)));
      end
      if (k > 0) begin
        checks++;
        if (fifo_push !== 1'b1 || sb.size() == 0 || fifo_push_data !== sb[0]) begin
          errors++;
          $display("FAIL fair_push[%0d]: push=%b data=%h expected %h", k, fifo_push, fifo_push_data, sb[0]);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      sb.push_back('{src_id: 2'(k % 4), data: 8'(8'h10 + (k % 4))});
      tick();
    end
    req_valid = 0;
    @(negedge clk);
    checks++;
    if (fifo_push !== 1'b1 || sb.size() == 0 || fifo_push_data !== sb[0]) begin
      errors++;
      $display("FAIL fair_last_push: push=%b data=%h expected %h", fifo_push, fifo_push_data, sb[0]);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    tick();
  endtask

  task automatic test_near_full();
    do_reset();
    en = 1; fifo_count = 15; req_data = 32'hD4C3B2A1; req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL nf_grant: got %b expected 0001", req_ready);
    end
    sb.push_back('{src_id: 2'd0, data: 8'hA1});
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL nf_block: ready=%b stall=%0d expected 0000 and 0", req_ready, stall_cnt);
    end
    checks++;
    if (fifo_push !== 1'b1 || sb.size() == 0 || fifo_push_data !== sb[0]) begin
      errors++;
      $display("FAIL nf_push: push=%b data=%h expected %h", fifo_push, fifo_push_data, sb[0]);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    tick();
    fifo_count = 16; fifo_full = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0 || stall_cnt !== 16'(k) || ovf_err !== 1'b0 || fifo_push !== 1'b0) begin
        errors++;
        $display("FAIL nf_full[%0d]: ready=%b stall=%0d ovf=%b push=%b expected 0000 %0d 0 0",
                 k, req_ready, stall_cnt, ovf_err, fifo_push, k);
      end
      tick();
    end
    fifo_count = 0; fifo_full = 0; req_valid = 0;
    tick();
  endtask

  task automatic test_en_toggle();
    do_reset();
    en = 1; fifo_count = 0; req_data = 32'h44332211; req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL en_grant: got %b expected 0001", req_ready);
    end
    sb.push_back('{src_id: 2'd0, data: 8'h11});
    tick();
    en = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || fifo_push !== 1'b1 || sb.size() == 0 || fifo_push_data !== sb[0]) begin
      errors++;
      $display("FAIL en_drop: ready=%b push=%b data=%h expected 0000 1 %h", req_ready, fifo_push, fifo_push_data, sb[0]);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || fifo_push !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL en_idle: ready=%b push=%b busy=%b expected 0000 0 1", req_ready, fifo_push, busy);
    end
    tick();
    en = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL en_resume: ready=%b stall=%0d expected 0010 0", req_ready, stall_cnt);
    end
    sb.push_back('{src_id: 2'd1, data: 8'h22});
    tick();
    req_valid = 0;
    @(negedge clk);
    checks++;
    if (fifo_push !== 1'b1 || sb.size() == 0 || fifo_push_data !== sb[0] || accept_cnt !== 16'd2) begin
      errors++;
      $display("FAIL en_push: push=%b data=%h acc=%0d expected 1 %h 2", fifo_push, fifo_push_data, accept_cnt, sb[0]);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL en_busy: got %b expected 0", busy);
    end
    tick();
  endtask

  task automatic test_stats();
    do_reset();
    en = 1; fifo_count = 0; req_data = 32'h44332211; req_valid = 4'hF;
    repeat (65534) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (accept_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL acc_fffe: got %h expected fffe", accept_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (accept_cnt !== 16'hFFFF) begin
        errors++;
        $display("FAIL acc_sat[%0d]: got %h expected ffff", k, accept_cnt);
      end
    end
    clr_stats = 1;
    @(negedge clk);
    checks++;
    if (req_ready === 4'b0) begin
      errors++;
      $display("FAIL clr_xfer: ready=%b expected a grant", req_ready);
    end
    tick();
    clr_stats = 0;
    @(negedge clk);
    checks++;
    if (accept_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_acc: got %0d expected 0", accept_cnt);
    end
    tick();
    fifo_full = 1;
    @(negedge clk);
    checks++;
    if (accept_cnt !== 16'd1 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL acc_after_clr: acc=%0d ovf=%b expected 1 0", accept_cnt, ovf_err);
    end
    tick();
    fifo_full = 0; req_valid = 0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", ovf_err);
    end
    clr_stats = 1;
    tick();
    clr_stats = 0;
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b0 || accept_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b acc=%0d expected 0 0", ovf_err, accept_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1; fifo_count = 0; req_data = 32'h44332211; req_valid = 4'hF;
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || fifo_push !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_hold: ready=%b push=%b expected 0000 1", req_ready, fifo_push);
    end
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (fifo_push !== 1'b0 || accept_cnt !== 16'd0 || stall_cnt !== 16'd0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_after: push=%b acc=%0d stall=%0d ready=%b expected 0 0 0 0001",
               fifo_push, accept_cnt, stall_cnt, req_ready);
    end
    sb.delete();
    req_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_near_full();
    test_en_toggle();
    test_stats();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_fifo_arb.md
Name: spike_fifo_arb

Overview:
- Shares one fifo_sync write port between NUM_SRC spike producers, e.g. per-tile spike encoders.
- Round-robin arbitration with a valid/ready handshake per source.
- Each accepted word is tagged with its source ID and pushed through a registered write stage.
- Tracks in-flight pushes against FIFO occupancy so the FIFO never overflows; keeps saturating statistics for the CSR block.

Parameters:
- NUM_SRC, 4, number of requesters (2..16)
- DATA_W, 8, payload width per requester
- FIFO_DEPTH, 16, depth of the attached fifo_sync; must match its DEPTH
- SRC_W, $clog2(NUM_SRC) (derived localparam), source ID tag width
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  arbitration enable; 0 = no grants, in-flight push still completes
- clr_stats  in  1  synchronous clear of accept_cnt, stall_cnt and ovf_err
- req_valid  in  NUM_SRC  per-source valid
- req_data  in  NUM_SRC*DATA_W  per-source payload; source i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_SRC  per-source ready (one-hot or zero)
- fifo_push  out  1  registered push to fifo_sync
- fifo_push_data  out  SRC_W+DATA_W  {src_id, data}
- fifo_full  in  1  from fifo_sync
- fifo_count  in  $clog2(FIFO_DEPTH+1)  from fifo_sync
- busy  out  1  fifo_push | (|req_valid)
- accept_cnt  out  CNT_W  words accepted; saturating
- stall_cnt  out  CNT_W  cycles with en & |req_valid & no grant; saturating
- ovf_err  out  1  sticky: fifo_push asserted while fifo_full

Behaviour:
- Reset (rst=1 at posedge) clears:
  - fifo_push=0, fifo_push_data=0
  - rr_ptr=0, so source 0 has highest priority
  - accept_cnt=0, stall_cnt=0, ovf_err=0
- req_ready is combinational and therefore also 0 while rst is held.
- Space check, combinational: space = (fifo_count + fifo_push) < FIFO_DEPTH.
  - fifo_push accounts for the registered push not yet reflected in fifo_count.
  - Pops are ignored, so the check is conservative.
- Grant, combinational:
  - If en & space & |req_valid: grant the first valid source searching from rr_ptr upward, wrapping NUM_SRC-1 -> 0.
  - req_ready = grant (one-hot); otherwise req_ready = 0.
- Handshake:
  - Transfer occurs on a cycle where req_valid[i] & req_ready[i].
  - A source must hold valid and data stable until ready.
  - req_ready never depends on the data value.
- Write stage: on transfer from source i, on the next posedge fifo_push<=1 and fifo_push_data<={i[SRC_W-1:0], data_i}. Otherwise fifo_push<=0. Latency: 1 cycle from acceptance to push.
- Pointer update: on transfer from source i, rr_ptr <= (i==NUM_SRC-1) ? 0 : i+1. It is unchanged on cycles with no grant.
- Throughput: one word per cycle while space holds.
  - Back-to-back grants at fifo_count=FIFO_DEPTH-1: at most one more word is accepted, since the in-flight push blocks the next one.
- Deassert of en mid-stream: no new grants; a push already registered still issues.
- Counters:
  - accept_cnt +1 per transfer.
  - stall_cnt +1 per cycle where en & |req_valid & ~space.
  - Both saturate at all-ones.
  - clr_stats takes priority over an increment in the same cycle; rst takes priority over clr_stats.
- ovf_err: set when fifo_push & fifo_full; cleared only by rst or clr_stats. It must never set when fifo_count is correct, and serves as an integration check.
- Reset mid-operation: an in-flight word is discarded and the pointer returns to 0. The attached FIFO is reset by the system reset controller.

Decomposition:
- snn_fifo_pkg holds:
  - a function computing SRC_W
  - typedef fifo_word_t packing {src_id, data}
  - a saturating-increment function
- One sub-module, rr_arbiter (NUM_SRC; inputs req, ptr, enable; outputs one-hot grant and encoded idx). It is purely combinational and reusable by the read-side scheduler.
- Pointer, write stage and counters stay in spike_fifo_arb.

Test Plan:
- Single source: en=1, src2 valid with data 0x5A from reset -> req_ready[2]=1 same cycle; next cycle fifo_push=1, fifo_push_data={2'd2,8'h5A}; accept_cnt=1.
- Fairness: all 4 sources held valid, FIFO drained each cycle -> grant order 0,1,2,3,0,1; each source granted exactly every 4th cycle.
- Near-full:
  - fifo_count=15, all valid -> exactly one grant, then req_ready=0 while fifo_count=15 & fifo_push=1.
  - fifo_count=16 -> no grant; stall_cnt increments each stalled cycle; ovf_err stays 0.
- en toggle: grant in cycle t with en dropped at t+1 -> push still appears at t+1, no grants at t+1.. while en=0; rr_ptr is preserved, so the next grant resumes at the following source.
- Stats:
  - accept_cnt preloaded to 0xFFFF via 65535 transfers, plus one more -> stays 0xFFFF.
  - clr_stats coincident with a transfer -> accept_cnt=0.
- Reset mid-burst: rst asserted while fifo_push=1 -> next cycle fifo_push=0, all counters 0, and the first post-reset grant goes to source 0 when all sources are valid.
